// File: rtl/nios_mult_cell_pipe_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | nios_mult_cell_pipe_if : op/result handshake bundle for the multiply |
// | pipe. Revision: 1.0                                                |
// +--------------------------------------------------------------------+
interface nios_mult_cell_pipe_if #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_op;
  logic [DATA_W-1:0] in_src1;
  logic [DATA_W-1:0] in_src2;
  logic [TAG_W-1:0]  in_tag;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;
  logic [TAG_W-1:0]  out_tag;

  modport master (
    output in_valid, in_op, in_src1, in_src2, in_tag, flush, out_ready,
    input  in_ready, out_valid, out_result, out_tag
  );

  modport slave (
    input  in_valid, in_op, in_src1, in_src2, in_tag, flush, out_ready,
    output in_ready, out_valid, out_result, out_tag
  );
endinterface
`default_nettype wire

// File: rtl/nios_mult_cell_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | nios_mult_cell_pipe : limb-decomposed pipelined MUL/MULH/MULHSU/MULHU|
// | NIOS_MULT_CELL_OUT_REG_EN adds an output retiming stage (lat 3).   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module nios_mult_cell_pipe #(
  parameter int DATA_W = 32,
  parameter int LIMB_W = 16,
  parameter int TAG_W  = 5
) (
  input  wire logic           clk,
  input  wire logic           reset_n,
  nios_mult_cell_pipe_if.slave bus
);
  localparam int c_NL = DATA_W / LIMB_W;
  localparam int c_NP = c_NL * c_NL;
  localparam int c_PW = 2 * LIMB_W;
  localparam int c_FW = 2 * DATA_W;

  logic              w_en;
  logic              w_accept;
  logic              w_out_valid;
  logic              w_a_sgn;
  logic              w_b_sgn;
  logic [DATA_W-1:0] w_corr;
  logic [c_PW-1:0]   w_pp [c_NP];
  logic [c_FW-1:0]   w_ext;
  logic [c_FW-1:0]   w_psum;
  logic [c_FW-1:0]   w_prod;
  logic [DATA_W-1:0] w_word;

  logic              r_s1_valid;
  logic [1:0]        r_s1_op;
  logic [TAG_W-1:0]  r_s1_tag;
  logic [DATA_W-1:0] r_s1_corr;
  logic [c_PW-1:0]   r_s1_pp [c_NP];

  logic              r_s2_valid;
  logic [DATA_W-1:0] r_s2_result;
  logic [TAG_W-1:0]  r_s2_tag;

  assign w_en        = ~w_out_valid | bus.out_ready;
  assign bus.in_ready = w_en & ~bus.flush;
  assign w_accept    = bus.in_valid & bus.in_ready;

  // MULH signs both operands, MULHSU only src1; MUL/MULHU are unsigned.
  assign w_a_sgn = (bus.in_op == 2'b01) | (bus.in_op == 2'b10);
  assign w_b_sgn = (bus.in_op == 2'b01);
  // The correction sits entirely in the high word, so only that half is kept.
  assign w_corr  = ((w_a_sgn & bus.in_src1[DATA_W-1]) ? bus.in_src2 : '0)
                 + ((w_b_sgn & bus.in_src2[DATA_W-1]) ? bus.in_src1 : '0);

  always_comb begin
    for (int i = 0; i < c_NL; i++) begin
      for (int j = 0; j < c_NL; j++) begin
        w_pp[i*c_NL+j] = c_PW'(bus.in_src1[i*LIMB_W +: LIMB_W])
                       * c_PW'(bus.in_src2[j*LIMB_W +: LIMB_W]);
      end
    end
  end

  always_comb begin
    w_psum = '0;
    w_ext  = '0;
    for (int k = 0; k < c_NP; k++) begin
      w_ext            = '0;
      w_ext[c_PW-1:0]  = r_s1_pp[k];
      w_psum           = w_psum + (w_ext << (LIMB_W * ((k / c_NL) + (k % c_NL))));
    end
  end

  assign w_prod = w_psum - {r_s1_corr, {DATA_W{1'b0}}};
  assign w_word = (r_s1_op == 2'b00) ? w_prod[DATA_W-1:0] : w_prod[c_FW-1:DATA_W];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_op     <= '0;
      r_s1_tag    <= '0;
      r_s1_corr   <= '0;
      r_s2_result <= '0;
      r_s2_tag    <= '0;
      for (int k = 0; k < c_NP; k++) begin
        r_s1_pp[k] <= '0;
      end
    end else if (w_en) begin
      r_s1_op     <= bus.in_op;
      r_s1_tag    <= bus.in_tag;
      r_s1_corr   <= w_corr;
      r_s2_result <= w_word;
      r_s2_tag    <= r_s1_tag;
      for (int k = 0; k < c_NP; k++) begin
        r_s1_pp[k] <= w_pp[k];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else if (bus.flush) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else if (w_en) begin
      r_s1_valid <= w_accept;
      r_s2_valid <= r_s1_valid;
    end
  end

`ifdef NIOS_MULT_CELL_OUT_REG_EN
  logic              r_s3_valid;
  logic [DATA_W-1:0] r_s3_result;
  logic [TAG_W-1:0]  r_s3_tag;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s3_valid  <= 1'b0;
      r_s3_result <= '0;
      r_s3_tag    <= '0;
    end else begin
      if (bus.flush) begin
        r_s3_valid <= 1'b0;
      end else if (w_en) begin
        r_s3_valid <= r_s2_valid;
      end
      if (w_en) begin
        r_s3_result <= r_s2_result;
        r_s3_tag    <= r_s2_tag;
      end
    end
  end

  assign w_out_valid    = r_s3_valid;
  assign bus.out_result = r_s3_result;
  assign bus.out_tag    = r_s3_tag;
`else
  assign w_out_valid    = r_s2_valid;
  assign bus.out_result = r_s2_result;
  assign bus.out_tag    = r_s2_tag;
`endif

  assign bus.out_valid = w_out_valid;
endmodule
`default_nettype wire
